// File: rtl/dds_update_scheduler_pkg.sv
// Shared constants for the DDS update scheduler: register-type encoding and
// the PID channel addresses of the first frequency/phase/amplitude register.
package dds_update_scheduler_pkg;

    // PID channel index of DDS0's frequency, phase and amplitude registers
    localparam int FREQ0  = 8;
    localparam int PHASE0 = 12;
    localparam int AMP0   = 16;

    // Number of register types held per DDS
    localparam int N_TYPES = 3;

    // Register-type encoding, also the type arbitration order
    localparam logic [1:0] TYPE_FREQ  = 2'd0;
    localparam logic [1:0] TYPE_PHASE = 2'd1;
    localparam logic [1:0] TYPE_AMP   = 2'd2;

    // Successor of a register type in the freq -> phase -> amp wrap order
    function automatic logic [1:0] next_type(input logic [1:0] t);
        return (t == TYPE_AMP) ? TYPE_FREQ : t + 2'd1;
    endfunction

endpackage

// File: rtl/dds_update_scheduler_rr_arbiter.sv
// N-way round-robin first-one finder: returns the first asserted request
// at or after ptr, wrapping modulo N.
module dds_update_scheduler_rr_arbiter #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx
);

    logic [W-1:0] cand;

    // Walk the requests starting at ptr and latch the first one that is set
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = ptr;
        for (int i = 0; i < N; i++) begin
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
            cand = (cand == W'(N - 1)) ? '0 : cand + W'(1);
        end
    end

endmodule

// File: rtl/dds_update_scheduler.sv
// Coalescing update scheduler between the PID output stream and the DDS
// controllers. One pending slot per (DDS, register type); a slot is issued
// to its controller only when that controller is idle and out of holdoff.
module dds_update_scheduler
    import dds_update_scheduler_pkg::*;
#(
    parameter int N_DDS      = 4,
    parameter int W_CHAN     = 5,
    parameter int W_DATA     = 48,
    parameter int FREQ_BASE  = FREQ0,
    parameter int PHASE_BASE = PHASE0,
    parameter int AMP_BASE   = AMP0,
    parameter int HOLDOFF    = 2,
    parameter int W_DROP     = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 dv_in,
    input  logic [W_CHAN-1:0]    chan_in,
    input  logic [W_DATA-1:0]    data_in,
    input  logic [N_DDS-1:0]     busy_in,
    output logic [N_DDS-1:0]     freq_dv_out,
    output logic [N_DDS-1:0]     phase_dv_out,
    output logic [N_DDS-1:0]     amp_dv_out,
    output logic [W_DATA-1:0]    data_out,
    output logic [3*N_DDS-1:0]   pending_out,
    output logic [W_DROP-1:0]    drop_cnt_out
);

    localparam int W_DDS  = (N_DDS > 1) ? $clog2(N_DDS) : 1;
    localparam int W_HOLD = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    logic [W_DATA-1:0]               slot_val [N_DDS][N_TYPES];
    logic [N_TYPES-1:0][N_DDS-1:0]   pend;
    logic [W_HOLD-1:0]               holdoff  [N_DDS];
    logic [1:0]                      type_ptr [N_DDS];
    logic [W_DDS-1:0]                rr_ptr;

    logic [31:0]                     chan_w;
    logic                            wr_hit;
    logic [W_DDS-1:0]                wr_dds;
    logic [1:0]                      wr_type;

    logic [N_DDS-1:0]                eligible;
    logic                            dds_valid;
    logic [W_DDS-1:0]                iss_dds;
    logic [N_DDS-1:0]                type_valid;
    logic [1:0]                      type_idx [N_DDS];
    logic [1:0]                      iss_type;
    logic                            issue_now;
    logic                            same_slot;

    assign chan_w      = 32'(chan_in);
    assign pending_out = pend;

    // Map the PID channel onto a (DDS, register type) slot; anything else is ignored
    always_comb begin
        wr_hit  = 1'b0;
        wr_dds  = '0;
        wr_type = TYPE_FREQ;
        if (dv_in) begin
            if (chan_w >= 32'(FREQ_BASE) && chan_w < 32'(FREQ_BASE + N_DDS)) begin
                wr_hit  = 1'b1;
                wr_type = TYPE_FREQ;
                wr_dds  = W_DDS'(chan_w - 32'(FREQ_BASE));
            end else if (chan_w >= 32'(PHASE_BASE) && chan_w < 32'(PHASE_BASE + N_DDS)) begin
                wr_hit  = 1'b1;
                wr_type = TYPE_PHASE;
                wr_dds  = W_DDS'(chan_w - 32'(PHASE_BASE));
            end else if (chan_w >= 32'(AMP_BASE) && chan_w < 32'(AMP_BASE + N_DDS)) begin
                wr_hit  = 1'b1;
                wr_type = TYPE_AMP;
                wr_dds  = W_DDS'(chan_w - 32'(AMP_BASE));
            end
        end
    end

    for (genvar d = 0; d < N_DDS; d++) begin : g_dds
        assign eligible[d] = !busy_in[d] && (holdoff[d] == '0) &&
                             (pend[TYPE_FREQ][d] || pend[TYPE_PHASE][d] || pend[TYPE_AMP][d]);

        dds_update_scheduler_rr_arbiter #(.N(N_TYPES), .W(2)) u_type_arb (
            .req       ({pend[TYPE_AMP][d], pend[TYPE_PHASE][d], pend[TYPE_FREQ][d]}),
            .ptr       (type_ptr[d]),
            .gnt_valid (type_valid[d]),
            .gnt_idx   (type_idx[d])
        );
    end

    dds_update_scheduler_rr_arbiter #(.N(N_DDS), .W(W_DDS)) u_dds_arb (
        .req       (eligible),
        .ptr       (rr_ptr),
        .gnt_valid (dds_valid),
        .gnt_idx   (iss_dds)
    );

    assign iss_type  = type_idx[iss_dds];
    assign issue_now = dds_valid && type_valid[iss_dds];
    assign same_slot = issue_now && wr_hit && (wr_dds == iss_dds) && (wr_type == iss_type);

    // Register the issue, advance the pointers and holdoffs, and capture writes
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            freq_dv_out  <= '0;
            phase_dv_out <= '0;
            amp_dv_out   <= '0;
            data_out     <= '0;
            drop_cnt_out <= '0;
            pend         <= '0;
            rr_ptr       <= '0;
            for (int d = 0; d < N_DDS; d++) begin
                holdoff[d]  <= '0;
                type_ptr[d] <= TYPE_FREQ;
                for (int t = 0; t < N_TYPES; t++) begin
                    slot_val[d][t] <= '0;
                end
            end
        end else begin
            freq_dv_out  <= '0;
            phase_dv_out <= '0;
            amp_dv_out   <= '0;

            for (int d = 0; d < N_DDS; d++) begin
                if (holdoff[d] != '0) begin
                    holdoff[d] <= holdoff[d] - W_HOLD'(1);
                end
            end

            if (issue_now) begin
                case (iss_type)
                    TYPE_FREQ:  freq_dv_out[iss_dds]  <= 1'b1;
                    TYPE_PHASE: phase_dv_out[iss_dds] <= 1'b1;
                    TYPE_AMP:   amp_dv_out[iss_dds]   <= 1'b1;
                    default:    ;
                endcase
                data_out                <= slot_val[iss_dds][iss_type];
                pend[iss_type][iss_dds] <= 1'b0;
                rr_ptr                  <= (iss_dds == W_DDS'(N_DDS - 1)) ? '0 : iss_dds + W_DDS'(1);
                type_ptr[iss_dds]       <= next_type(iss_type);
                holdoff[iss_dds]        <= W_HOLD'(HOLDOFF);
            end

            // A write to the slot being issued re-arms it without counting as a drop
            if (wr_hit) begin
                slot_val[wr_dds][wr_type] <= data_in;
                pend[wr_type][wr_dds]     <= 1'b1;
                if (pend[wr_type][wr_dds] && !same_slot && (drop_cnt_out != '1)) begin
                    drop_cnt_out <= drop_cnt_out + W_DROP'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dds_update_scheduler.sv
// Directed bench for dds_update_scheduler with an expected-issue scoreboard.
module tb_dds_update_scheduler;

    localparam int N_DDS   = 4;
    localparam int HOLDOFF = 2;
    localparam int FB      = 8;
    localparam int PB      = 12;
    localparam int AB      = 16;

    logic        clk_in   = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        dv_in    = 1'b0;
    logic [4:0]  chan_in  = '0;
    logic [47:0] data_in  = '0;
    logic [3:0]  busy_in  = '0;
    logic [3:0]  freq_dv_out;
    logic [3:0]  phase_dv_out;
    logic [3:0]  amp_dv_out;
    logic [47:0] data_out;
    logic [11:0] pending_out;
    logic [15:0] drop_cnt_out;

    typedef struct packed {
        logic [3:0]  f;
        logic [3:0]  p;
        logic [3:0]  a;
        logic [47:0] data;
        logic [1:0]  dds;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;
    int   last_strobe [N_DDS];

    dds_update_scheduler dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .dv_in        (dv_in),
        .chan_in      (chan_in),
        .data_in      (data_in),
        .busy_in      (busy_in),
        .freq_dv_out  (freq_dv_out),
        .phase_dv_out (phase_dv_out),
        .amp_dv_out   (amp_dv_out),
        .data_out     (data_out),
        .pending_out  (pending_out),
        .drop_cnt_out (drop_cnt_out)
    );

    // 50 MHz clock
    always #10 clk_in = ~clk_in;

    // Compare one observed value against its expectation and count the result
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present one PID write for a single clock cycle, starting at a falling edge
    task automatic applyStimulus(input logic [4:0] ch, input logic [47:0] d);
        dv_in   = 1'b1;
        chan_in = ch;
        data_in = d;
        @(negedge clk_in);
        dv_in   = 1'b0;
    endtask

    task automatic pushExp(input logic [3:0] f, input logic [3:0] p, input logic [3:0] a,
                           input logic [47:0] d, input logic [1:0] dds);
        exp_t e;
        e.f = f; e.p = p; e.a = a; e.data = d; e.dds = dds;
        expq.push_back(e);
    endtask

    // Wait, bounded, for the scoreboard to empty
    task automatic waitDrain(input int max_cycles);
        int n;
        n = 0;
        while (expq.size() != 0 && n < max_cycles) begin
            @(negedge clk_in);
            n++;
        end
        checkOutput("drain", 64'(expq.size()), 64'd0);
        expq.delete();
    endtask

    task automatic clearHistory();
        for (int i = 0; i < N_DDS; i++) last_strobe[i] = -100;
        expq.delete();
    endtask

    task automatic doReset();
        @(negedge clk_in);
        rst_n_in = 1'b0;
        clearHistory();
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);
    endtask

    // Scoreboard consumer: every strobe must match the oldest expected issue
    always @(negedge clk_in) begin
        cycle = cycle + 1;
        if (rst_n_in && ((freq_dv_out | phase_dv_out | amp_dv_out) != 4'b0)) begin
            if (expq.size() == 0) begin
                checkOutput("unexpected_strobe", 64'({freq_dv_out, phase_dv_out, amp_dv_out}), 64'd0);
            end else begin
                mon_e = expq.pop_front();
                checkOutput("strobe_vec", 64'({freq_dv_out, phase_dv_out, amp_dv_out}),
                            64'({mon_e.f, mon_e.p, mon_e.a}));
                checkOutput("strobe_data", 64'(data_out), 64'(mon_e.data));
                if (last_strobe[mon_e.dds] >= 0) begin
                    checkOutput("dds_spacing", 64'((cycle - last_strobe[mon_e.dds]) >= HOLDOFF + 1), 64'd1);
                end
                last_strobe[mon_e.dds] = cycle;
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        clearHistory();
        rst_n_in = 1'b0;
        busy_in  = 4'h0;
        repeat (3) @(negedge clk_in);
        checkOutput("reset_freq",    64'(freq_dv_out),  64'd0);
        checkOutput("reset_phase",   64'(phase_dv_out), 64'd0);
        checkOutput("reset_amp",     64'(amp_dv_out),   64'd0);
        checkOutput("reset_data",    64'(data_out),     64'd0);
        checkOutput("reset_pending", 64'(pending_out),  64'd0);
        checkOutput("reset_drop",    64'(drop_cnt_out), 64'd0);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        $display("[TB] single write");
        pushExp(4'b0010, 4'b0, 4'b0, 48'h123456789ABC, 2'd1);
        applyStimulus(5'(FB + 1), 48'h123456789ABC);
        checkOutput("single_pending", 64'(pending_out), 64'h002);
        checkOutput("single_early",   64'(freq_dv_out), 64'd0);
        @(negedge clk_in);
        checkOutput("single_strobe",  64'(freq_dv_out), 64'b0010);
        checkOutput("single_data",    64'(data_out),    64'h123456789ABC);
        @(negedge clk_in);
        checkOutput("single_clear",   64'(pending_out),  64'd0);
        checkOutput("single_onecyc",  64'(freq_dv_out),  64'd0);
        checkOutput("single_hold",    64'(data_out),     64'h123456789ABC);
        checkOutput("single_drop",    64'(drop_cnt_out), 64'd0);

        $display("[TB] out-of-range channels");
        applyStimulus(5'd0,  48'hDEAD);
        applyStimulus(5'd20, 48'hBEEF);
        applyStimulus(5'd7,  48'hCAFE);
        applyStimulus(5'd31, 48'hF00D);
        repeat (4) @(negedge clk_in);
        checkOutput("oor_pending", 64'(pending_out),  64'd0);
        checkOutput("oor_drop",    64'(drop_cnt_out), 64'd0);

        $display("[TB] coalescing");
        busy_in = 4'b0001;
        applyStimulus(5'(PB), 48'h100);
        applyStimulus(5'(PB), 48'h200);
        applyStimulus(5'(PB), 48'h300);
        checkOutput("coal_drop",    64'(drop_cnt_out), 64'd2);
        checkOutput("coal_pending", 64'(pending_out),  64'h010);
        repeat (6) @(negedge clk_in);
        checkOutput("coal_blocked", 64'(pending_out),  64'h010);
        pushExp(4'b0, 4'b0001, 4'b0, 48'h300, 2'd0);
        busy_in = 4'b0000;
        waitDrain(20);
        checkOutput("coal_clear",     64'(pending_out),  64'd0);
        checkOutput("coal_drop_keep", 64'(drop_cnt_out), 64'd2);

        $display("[TB] fairness");
        doReset();
        checkOutput("fair_drop_reset", 64'(drop_cnt_out), 64'd0);
        busy_in = 4'hF;
        for (int ch = FB; ch < AB + N_DDS; ch++) begin
            applyStimulus(5'(ch), 48'hA00 + 48'(ch));
        end
        checkOutput("fair_pending", 64'(pending_out),  64'hFFF);
        checkOutput("fair_drop",    64'(drop_cnt_out), 64'd0);
        for (int t = 0; t < 3; t++) begin
            for (int d = 0; d < N_DDS; d++) begin
                logic [3:0] v;
                v = 4'(1 << d);
                pushExp((t == 0) ? v : 4'b0, (t == 1) ? v : 4'b0, (t == 2) ? v : 4'b0,
                        48'hA00 + 48'(FB + 4 * t + d), 2'(d));
            end
        end
        busy_in = 4'h0;
        waitDrain(100);
        checkOutput("fair_clear", 64'(pending_out), 64'd0);

        $display("[TB] same-cycle write and issue");
        busy_in = 4'b0100;
        applyStimulus(5'(AB + 2), 48'h155);
        checkOutput("same_pending_old", 64'(pending_out), 64'h400);
        pushExp(4'b0, 4'b0, 4'b0100, 48'h155, 2'd2);
        pushExp(4'b0, 4'b0, 4'b0100, 48'h3FF, 2'd2);
        busy_in = 4'b0000;
        applyStimulus(5'(AB + 2), 48'h3FF);
        checkOutput("same_strobe",      64'(amp_dv_out),   64'b0100);
        checkOutput("same_pending_new", 64'(pending_out),  64'h400);
        checkOutput("same_drop",        64'(drop_cnt_out), 64'd0);
        waitDrain(20);
        checkOutput("same_clear",      64'(pending_out),  64'd0);
        checkOutput("same_drop_final", 64'(drop_cnt_out), 64'd0);

        $display("[TB] asynchronous reset");
        busy_in = 4'hF;
        for (int ch = FB; ch < FB + 6; ch++) begin
            applyStimulus(5'(ch), 48'hB00 + 48'(ch));
        end
        checkOutput("areset_pending_before", 64'(pending_out), 64'h03F);
        pushExp(4'b1000, 4'b0, 4'b0, 48'hB00 + 48'(FB + 3), 2'd3);
        busy_in = 4'h0;
        @(negedge clk_in);
        #2;
        checkOutput("areset_strobe_before", 64'(freq_dv_out), 64'b1000);
        #1;
        rst_n_in = 1'b0;
        clearHistory();
        #1;
        checkOutput("areset_freq",    64'(freq_dv_out),  64'd0);
        checkOutput("areset_phase",   64'(phase_dv_out), 64'd0);
        checkOutput("areset_amp",     64'(amp_dv_out),   64'd0);
        checkOutput("areset_pending", 64'(pending_out),  64'd0);
        #33;
        rst_n_in = 1'b1;
        repeat (10) @(negedge clk_in);
        checkOutput("areset_quiet_pending", 64'(pending_out),  64'd0);
        checkOutput("areset_quiet_drop",    64'(drop_cnt_out), 64'd0);
        pushExp(4'b0, 4'b0, 4'b0001, 48'hABC, 2'd0);
        applyStimulus(5'(AB), 48'hABC);
        waitDrain(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
